// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader: FSM state encoding and default frame marker.
package loader_pkg;

    localparam int unsigned STATE_W = 3;
    localparam logic [7:0]  DEFAULT_SYNC_BYTE = 8'hA5;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_CHK,
        ST_DONE,
        ST_ERROR
    } state_e;

    function automatic logic in_frame(input state_e s);
        return s inside {ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO, ST_CHK};
    endfunction

endpackage

// File: rtl/loader_timeout.sv
// Reloadable idle counter: o_expired flags the TIMEOUT-th consecutive enabled cycle without a kick.
module loader_timeout #(
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_enable,
    input  logic i_kick,
    output logic o_expired
);

    localparam int unsigned    CW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0]  LIMIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!i_enable || i_kick) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_expired = i_enable && !i_kick && (cnt_q == LIMIT);

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream loader writing 16-bit words into instruction memory while stalling the core.
// Optional trailing checksum byte enabled by defining PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned TIMEOUT    = 65535,
    parameter logic [7:0]  SYNC_BYTE  = DEFAULT_SYNC_BYTE
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    input  logic [7:0]            i_byte,
    output logic                  o_ready,
    output logic                  o_load,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [15:0]           o_data,
    output logic                  o_core_hold,
    output logic                  o_done,
    output logic                  o_error
);

    localparam int unsigned IW      = ADDR_WIDTH + 1;
    localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_WIDTH;

    state_e                state_q, state_d;
    logic [7:0]            len_hi_q, len_hi_d;
    logic [IW-1:0]         len_q, len_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [7:0]            hi_q, hi_d;
    logic                  load_q, load_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           data_q, data_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  hold_q, hold_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]            sum_q, sum_d;
`endif

    logic [16:0]   frame_len;
    logic [IW-1:0] idx_next;
    logic          expired;

    assign frame_len = {1'b0, len_hi_q, i_byte};
    assign idx_next  = idx_q + 1'b1;

    loader_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_enable  (in_frame(state_q)),
        .i_kick    (i_valid),
        .o_expired (expired)
    );

    always_comb begin
        state_d  = state_q;
        len_hi_d = len_hi_q;
        len_d    = len_q;
        idx_d    = idx_q;
        hi_d     = hi_q;
        load_d   = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        done_d   = done_q;
        error_d  = error_q;
        hold_d   = hold_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        sum_d    = sum_q;
`endif
        if (expired) begin
            state_d = ST_ERROR;
            error_d = 1'b1;
        end else if (i_valid) begin
            unique case (state_q)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (i_byte == SYNC_BYTE) begin
                        state_d = ST_LEN_HI;
                        hold_d  = 1'b1;
                        done_d  = 1'b0;
                        error_d = 1'b0;
                        idx_d   = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        sum_d   = '0;
`endif
                    end
                end
                ST_LEN_HI: begin
                    len_hi_d = i_byte;
                    state_d  = ST_LEN_LO;
                end
                ST_LEN_LO: begin
                    // Length is checked in 17 bits so exactly 2^ADDR_WIDTH words is accepted.
                    if (frame_len == '0 || frame_len > MAX_LEN) begin
                        state_d = ST_ERROR;
                        error_d = 1'b1;
                    end else begin
                        len_d   = frame_len[IW-1:0];
                        state_d = ST_DATA_HI;
                    end
                end
                ST_DATA_HI: begin
                    hi_d    = i_byte;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    sum_d   = sum_q + i_byte;
`endif
                    state_d = ST_DATA_LO;
                end
                ST_DATA_LO: begin
                    load_d = 1'b1;
                    addr_d = idx_q[ADDR_WIDTH-1:0];
                    data_d = {hi_q, i_byte};
                    idx_d  = idx_next;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    sum_d  = sum_q + i_byte;
`endif
                    if (idx_next == len_q) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        state_d = ST_CHK;
`else
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
`endif
                    end else begin
                        state_d = ST_DATA_HI;
                    end
                end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                ST_CHK: begin
                    if (i_byte == sum_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = ST_ERROR;
                        error_d = 1'b1;
                    end
                end
`endif
                default: begin
                    state_d = ST_ERROR;
                    error_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            len_hi_q <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            hi_q     <= '0;
            load_q   <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            hold_q   <= 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            len_hi_q <= len_hi_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            hi_q     <= hi_d;
            load_q   <= load_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            done_q   <= done_d;
            error_q  <= error_d;
            hold_q   <= hold_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum_q    <= sum_d;
`endif
        end
    end

    assign o_ready     = 1'b1;
    assign o_load      = load_q;
    assign o_addr      = addr_q;
    assign o_data      = data_q;
    assign o_core_hold = hold_q;
    assign o_done      = done_q;
    assign o_error     = error_q;

endmodule
